seq_fsm_gen: RTL and testbench
==============================

// Module: seq_fsm_gen
// PURPOSE
//  Parametrised synchronous sequence generator. Steps a W-bit state register through
//  a programmable DEPTH-entry code sequence, forward or reverse, with hold and jam load.
//  Drives a Moore flag Z on a target code; any off-sequence code recovers in one step.
//  Replaces fixed-sequence hand-built counters; sits under the lab top, driven by jam switches.
// PARAMETERS
//  W            4                                   state code width (bits)
//  DEPTH        12                                  sequence length, 2..2**W
//  SEQ          {5,10,1,8,3,4,14,12,6,13,7,2}       packed W*DEPTH; entry k = SEQ[k*W +: W]; entry 0 = 2
//  Z_CODE       7                                   code on which Z is high
//  RECOVER_IDX  0                                   index entered from an illegal code
// PORTS
//  Clk          in   1      rising-edge clock
//  Reset_n      in   1      async active-low reset
//  Enable       in   1      1 = advance one step per clock; 0 = hold
//  Dir          in   1      0 = forward (k -> k+1); 1 = reverse (k -> k-1)
//  JAM_Enable   in   1      synchronous load of JAM_Data; overrides Enable
//  JAM_Data     in   W      code to load (legal or illegal)
//  Q            out  W      current state code (registered)
//  Idx          out  clog2(DEPTH)  sequence index of Q; 0 while Q is illegal
//  Z            out  1      Moore: Q == Z_CODE (combinational from Q only)
//  Illegal      out  1      Q matches no SEQ entry (combinational from Q)
//  Wrap         out  1      registered 1-cycle pulse on a wrap step
// BEHAVIOUR
//  - Reset (async assert, sync-safe release): Q = SEQ entry 0, Wrap = 0, so Idx = 0,
//    Illegal = 0, and Z = (entry 0 == Z_CODE). Mid-operation reset wins immediately.
//  - Lookup: Idx = lowest k with SEQ[k] == Q; Illegal = no match.
//    Duplicate SEQ entries are a configuration error; the lowest index wins.
//  - Next state per rising edge, in priority order:
//     1. JAM_Enable = 1: Q <= JAM_Data, even if the code is illegal; Wrap <= 0.
//     2. Illegal = 1: Q <= SEQ[RECOVER_IDX], regardless of Enable; Wrap <= 0.
//     3. Enable = 0: hold Q; Wrap <= 0.
//     4. Dir = 0: Q <= SEQ[(Idx + 1) mod DEPTH]; Wrap <= (Idx == DEPTH-1).
//     5. Dir = 1: Q <= SEQ[(Idx + DEPTH - 1) mod DEPTH]; Wrap <= (Idx == 0).
//  - Index arithmetic: clog2(DEPTH)-bit compare-and-wrap; no reliance on power-of-2 overflow.
//  - Latency: one clock from input change to Q. Z, Idx and Illegal follow Q in the same cycle.
//  - Dir may change on any cycle; it takes effect on the next step with no glitch.
//  - When DEPTH == 2**W, Illegal is constantly 0 and the recovery path is dead logic.
//  - Elaboration checks: DEPTH < 2 or DEPTH > 2**W, RECOVER_IDX >= DEPTH -> $error.
// STRUCTURE
//  - seq_fsm_pkg: default SEQ constant; function idx_step(idx, dir, depth) -> next idx
//    and wrap flag; the clog2 width helper.
//  - Sub-module seq_lookup: parametrised W/DEPTH/SEQ code->index priority encoder with
//    match flag. Instantiated once; also reusable by the bench scoreboard.
//  - Top: state register, next-state mux, Wrap register, output assigns.
// TESTING
//  1. Reset, Enable = 1, Dir = 0 for 26 clocks -> Q follows 2,7,13,6,12,14,4,3,8,1,10,5
//     twice; Wrap pulses on each 5->2 step; Z is high only while Q = 7.
//  2. JAM 9 (illegal) for 1 clock -> Q = 9 and Illegal = 1 for one cycle, then Q = 2 and
//     stepping resumes. Repeat with Enable = 0: recovery to 2 still occurs, then Q holds.
//  3. JAM 14 with Dir = 1 -> Q = 12,6,13,7,2,5 with Wrap on the 2->5 step. Toggle Dir at
//     Q = 7 -> next Q = 13.
//  4. Enable = 0 for 5 clocks at Q = 6 -> Q stays 6, Wrap stays 0. JAM_Enable with
//     Enable = 0 -> the load still occurs.
//  5. Assert Reset_n low mid-cycle at Q = 8, asynchronously to Clk -> Q = 2 at once,
//     before the next edge; Wrap = 0.
//  6. Re-elaborate W = 3, DEPTH = 8, SEQ = gray order, Z_CODE = 4 -> full cycle is
//     correct, Illegal is never 1, Wrap fires every 8 steps.

Source files
------------

// File: rtl/seq_fsm_pkg.sv
// Shared types, default sequence and index helpers for the programmable sequence generator.
package seq_fsm_pkg;

  // Entry 0 sits in the least significant nibble: 2,7,13,6,12,14,4,3,8,1,10,5.
  localparam logic [47:0] SEQ_DEFAULT = {4'd5, 4'd10, 4'd1, 4'd8, 4'd3, 4'd4,
                                         4'd14, 4'd12, 4'd6, 4'd13, 4'd7, 4'd2};

  typedef struct packed {
    logic        wrap;
    logic [31:0] idx;
  } step_t;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Explicit compare-and-wrap so non-power-of-2 depths never rely on overflow.
  function automatic step_t idx_step(input logic [31:0] idx, input logic dir,
                                     input logic [31:0] depth);
    step_t s;
    s.wrap = 1'b0;
    s.idx  = idx;
    if (!dir) begin
      if (idx == depth - 32'd1) begin
        s.idx  = '0;
        s.wrap = 1'b1;
      end else begin
        s.idx = idx + 32'd1;
      end
    end else begin
      if (idx == '0) begin
        s.idx  = depth - 32'd1;
        s.wrap = 1'b1;
      end else begin
        s.idx = idx - 32'd1;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/seq_lookup.sv
// Code-to-index priority encoder over a packed code table; lowest matching index wins.
module seq_lookup
  import seq_fsm_pkg::*;
#(
  parameter int                   W     = 4,
  parameter int                   DEPTH = 12,
  parameter logic [W*DEPTH-1:0]   SEQ   = SEQ_DEFAULT
) (
  input  logic [W-1:0]                code,
  output logic [idx_w(DEPTH)-1:0]     idx,
  output logic                        match
);

  localparam int IW = idx_w(DEPTH);

  // Descending scan so the lowest index overwrites any later duplicate.
  always_comb begin
    idx   = '0;
    match = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (code == SEQ[k*W +: W]) begin
        idx   = IW'(k);
        match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_fsm_gen.sv
// Programmable sequence generator: steps through a code table forward or reverse,
// with hold, jam load, one-step recovery from off-sequence codes and a wrap pulse.
module seq_fsm_gen
  import seq_fsm_pkg::*;
#(
  parameter int                 W           = 4,
  parameter int                 DEPTH       = 12,
  parameter logic [W*DEPTH-1:0] SEQ         = SEQ_DEFAULT,
  parameter int                 Z_CODE      = 7,
  parameter int                 RECOVER_IDX = 0
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     Enable,
  input  logic                     Dir,
  input  logic                     JAM_Enable,
  input  logic [W-1:0]             JAM_Data,
  output logic [W-1:0]             Q,
  output logic [idx_w(DEPTH)-1:0]  Idx,
  output logic                     Z,
  output logic                     Illegal,
  output logic                     Wrap
);

  localparam int         IW = idx_w(DEPTH);
  localparam logic [W-1:0] Z_VAL = W'(Z_CODE);

  if (DEPTH < 2 || DEPTH > (1 << W)) begin : g_bad_depth
    $error("seq_fsm_gen: DEPTH %0d outside 2..2**W", DEPTH);
  end
  if (RECOVER_IDX < 0 || RECOVER_IDX >= DEPTH) begin : g_bad_recover
    $error("seq_fsm_gen: RECOVER_IDX %0d not below DEPTH", RECOVER_IDX);
  end

  logic [W-1:0]  q_r;
  logic [W-1:0]  q_nxt;
  logic          wrap_r;
  logic          wrap_nxt;
  logic [IW-1:0] idx;
  logic          match;
  step_t         step;

  seq_lookup #(
    .W     (W),
    .DEPTH (DEPTH),
    .SEQ   (SEQ)
  ) u_lookup (
    .code  (q_r),
    .idx   (idx),
    .match (match)
  );

  // Jam beats recovery, recovery beats hold, hold beats stepping.
  always_comb begin
    q_nxt    = q_r;
    wrap_nxt = 1'b0;
    step     = idx_step(32'(idx), Dir, 32'(DEPTH));
    if (JAM_Enable) begin
      q_nxt = JAM_Data;
    end else if (!match) begin
      q_nxt = SEQ[RECOVER_IDX*W +: W];
    end else if (Enable) begin
      q_nxt    = SEQ[step.idx*W +: W];
      wrap_nxt = step.wrap;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      q_r    <= SEQ[0 +: W];
      wrap_r <= 1'b0;
    end else begin
      q_r    <= q_nxt;
      wrap_r <= wrap_nxt;
    end
  end

  assign Q       = q_r;
  assign Idx     = idx;
  assign Z       = (q_r == Z_VAL);
  assign Illegal = !match;
  assign Wrap    = wrap_r;

endmodule

// File: tb/tb_seq_fsm_gen.sv
// Bench for seq_fsm_gen: default 12-entry instance plus a 3-bit gray-order instance,
// checked every cycle against a table-driven model plus literal sequence expectations.
module tb_seq_fsm_gen;

  logic       clk;
  logic       rst_n;
  logic       en_a, dir_a, jam_a;
  logic [3:0] jd_a;
  logic [3:0] qa, ia;
  logic       za, ila, wa;
  logic       en_b, dir_b, jam_b;
  logic [2:0] jd_b;
  logic [2:0] qb, ib;
  logic       zb, ilb, wb;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 0;

  int seq_tab [2][16] = '{'{2, 7, 13, 6, 12, 14, 4, 3, 8, 1, 10, 5, -1, -1, -1, -1},
                          '{0, 1, 3, 2, 6, 7, 5, 4, -1, -1, -1, -1, -1, -1, -1, -1}};
  int dep [2]  = '{12, 8};
  int zc  [2]  = '{7, 4};
  int lit_a [12] = '{2, 7, 13, 6, 12, 14, 4, 3, 8, 1, 10, 5};
  int lit_b [8]  = '{0, 1, 3, 2, 6, 7, 5, 4};

  int m_q    [2];
  bit m_wrap [2];

  seq_fsm_gen dut_a (
    .Clk(clk), .Reset_n(rst_n), .Enable(en_a), .Dir(dir_a), .JAM_Enable(jam_a),
    .JAM_Data(jd_a), .Q(qa), .Idx(ia), .Z(za), .Illegal(ila), .Wrap(wa)
  );

  seq_fsm_gen #(
    .W(3), .DEPTH(8), .SEQ({3'd4, 3'd5, 3'd7, 3'd6, 3'd2, 3'd3, 3'd1, 3'd0}),
    .Z_CODE(4), .RECOVER_IDX(0)
  ) dut_b (
    .Clk(clk), .Reset_n(rst_n), .Enable(en_b), .Dir(dir_b), .JAM_Enable(jam_b),
    .JAM_Data(jd_b), .Q(qb), .Idx(ib), .Z(zb), .Illegal(ilb), .Wrap(wb)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic int find(int b, int q);
    for (int k = 0; k < dep[b]; k++)
      if (seq_tab[b][k] == q) return k;
    return -1;
  endfunction

  function automatic int nxt_q(int b, int q, bit jam, int jd, bit en, bit dir);
    int i = find(b, q);
    int d = dep[b];
    if (jam) return jd;
    if (i < 0) return seq_tab[b][0];
    if (!en) return q;
    if (!dir) return seq_tab[b][(i + 1) % d];
    return seq_tab[b][(i + d - 1) % d];
  endfunction

  function automatic bit nxt_w(int b, int q, bit jam, bit en, bit dir);
    int i = find(b, q);
    if (jam || i < 0 || !en) return 0;
    return dir ? (i == 0) : (i == dep[b] - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q[0]    <= seq_tab[0][0];
      m_q[1]    <= seq_tab[1][0];
      m_wrap[0] <= 0;
      m_wrap[1] <= 0;
    end else begin
      m_q[0]    <= nxt_q(0, m_q[0], jam_a, int'(jd_a), en_a, dir_a);
      m_wrap[0] <= nxt_w(0, m_q[0], jam_a, en_a, dir_a);
      m_q[1]    <= nxt_q(1, m_q[1], jam_b, int'(jd_b), en_b, dir_b);
      m_wrap[1] <= nxt_w(1, m_q[1], jam_b, en_b, dir_b);
    end
  end

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("a_q",    int'(qa),  m_q[0]);
      check("a_idx",  int'(ia),  (find(0, m_q[0]) < 0) ? 0 : find(0, m_q[0]));
      check("a_z",    int'(za),  int'(m_q[0] == zc[0]));
      check("a_ill",  int'(ila), int'(find(0, m_q[0]) < 0));
      check("a_wrap", int'(wa),  int'(m_wrap[0]));
      check("b_q",    int'(qb),  m_q[1]);
      check("b_idx",  int'(ib),  (find(1, m_q[1]) < 0) ? 0 : find(1, m_q[1]));
      check("b_z",    int'(zb),  int'(m_q[1] == zc[1]));
      check("b_ill",  int'(ilb), int'(find(1, m_q[1]) < 0));
      check("b_wrap", int'(wb),  int'(m_wrap[1]));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic jam_a_once(int code, bit en, bit dir);
    jam_a = 1; jd_a = 4'(code); en_a = en; dir_a = dir;
    tick();
    jam_a = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    en_a = 0; dir_a = 0; jam_a = 0; jd_a = 0;
    en_b = 0; dir_b = 0; jam_b = 0; jd_b = 0;
    rst_n = 1;
    #1 rst_n = 0;
    tick();
    chk_on = 1;
    check("rst_a_q", int'(qa), 2);
    check("rst_a_idx", int'(ia), 0);
    check("rst_a_ill", int'(ila), 0);
    check("rst_a_z", int'(za), 0);
    check("rst_a_wrap", int'(wa), 0);
    check("rst_b_q", int'(qb), 0);
    rst_n = 1;
    en_a = 1; en_b = 1;

    // Forward run: two full passes of the default table and gray order.
    for (int i = 0; i < 26; i++) begin
      tick();
      check("fwd_a_q", int'(qa), lit_a[(i + 1) % 12]);
      check("fwd_a_wrap", int'(wa), int'(lit_a[i % 12] == 5));
      check("fwd_a_z", int'(za), int'(lit_a[(i + 1) % 12] == 7));
      check("gray_b_q", int'(qb), lit_b[(i + 1) % 8]);
      check("gray_b_wrap", int'(wb), int'(lit_b[i % 8] == 4));
    end

    // Illegal jam and recovery, stepping and held.
    jam_a_once(9, 1, 0);
    check("jam9_q", int'(qa), 9);
    check("jam9_ill", int'(ila), 1);
    tick();
    check("rec_q", int'(qa), 2);
    check("rec_ill", int'(ila), 0);
    tick();
    check("resume_q", int'(qa), 7);
    jam_a_once(9, 0, 0);
    check("jam9h_q", int'(qa), 9);
    tick();
    check("rech_q", int'(qa), 2);
    tick();
    check("hold_q", int'(qa), 2);

    // Reverse stepping with a direction toggle at 7.
    jam_a_once(14, 1, 1);
    check("jam14_q", int'(qa), 14);
    tick(); check("rev_q0", int'(qa), 12);
    tick(); check("rev_q1", int'(qa), 6);
    tick(); check("rev_q2", int'(qa), 13);
    tick(); check("rev_q3", int'(qa), 7);
    dir_a = 0;
    tick(); check("toggle_q", int'(qa), 13);
    jam_a_once(13, 1, 1);
    tick(); check("rev_q4", int'(qa), 7);
    tick(); check("rev_q5", int'(qa), 2);
    check("rev_nowrap", int'(wa), 0);
    tick(); check("rev_q6", int'(qa), 5);
    check("rev_wrap", int'(wa), 1);

    // Hold at 6, then jam while disabled.
    jam_a_once(6, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold6_q", int'(qa), 6);
      check("hold6_wrap", int'(wa), 0);
    end
    jam_a_once(3, 0, 0);
    check("jam_dis_q", int'(qa), 3);

    // Asynchronous reset mid-cycle at Q = 8.
    jam_a_once(8, 0, 0);
    check("pre_rst_q", int'(qa), 8);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("arst_a_q", int'(qa), 2);
    check("arst_a_wrap", int'(wa), 0);
    check("arst_b_q", int'(qb), 0);
    tick();
    rst_n = 1;

    // Randomized traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      en_a  = ($urandom_range(0, 9) < 8);
      dir_a = $urandom_range(0, 3) == 0 ? ~dir_a : dir_a;
      jam_a = ($urandom_range(0, 9) == 0);
      jd_a  = 4'($urandom_range(0, 15));
      en_b  = ($urandom_range(0, 9) < 8);
      dir_b = $urandom_range(0, 3) == 0 ? ~dir_b : dir_b;
      jam_b = ($urandom_range(0, 15) == 0);
      jd_b  = 3'($urandom_range(0, 7));
      tick();
    end

    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
